register_file_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_read_port.sv | 42 ++++
 rtl/register_file_mp.sv | 99 +++++++++
 tb/tb_register_file_mp.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  // Upper bound on write ports; match vectors are zero-extended to this width.
  localparam int unsigned MAX_WR = 16;

  // Highest set bit of a write-port match vector wins; returns 0 when none set.
  function automatic int unsigned win_idx(input logic [MAX_WR-1:0] match);
    win_idx = 0;
    for (int unsigned i = 0; i < MAX_WR; i++) begin
      if (match[i]) win_idx = i;
    end
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read lane: zero-register masking, clear gating and
// same-cycle write bypass with highest-port priority.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_WR   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic [ADDR_W-1:0]        addr,
  input  logic [NUM_WR-1:0]        reg_write,
  input  logic [NUM_WR*ADDR_W-1:0] write_register,
  input  logic [NUM_WR*DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0]        mem_row,
  input  logic                     clearing,
  output logic [DATA_W-1:0]        read_data
);

  logic [NUM_WR-1:0] match;
  int unsigned       win;
  logic              addr_is_zero;

  assign addr_is_zero = ZERO_REG && (addr == '0);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    match = '0;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      match[w] = reg_write[w] && (write_register[w*ADDR_W +: ADDR_W] == addr);
    end
    win = win_idx(MAX_WR'(match));

    read_data = mem_row;
    if (clearing || addr_is_zero) begin
      read_data = '0;
    end else if (|match) begin
      read_data = write_data[win*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file with write priority, same-cycle
// bypass, and a post-reset sequencer that clears storage before raising ready.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] read_register,
  output logic [NUM_RD*DATA_W-1:0] read_data,
  input  logic [NUM_WR-1:0]        reg_write,
  input  logic [NUM_WR*ADDR_W-1:0] write_register,
  input  logic [NUM_WR*DATA_W-1:0] write_data,
  output logic                     ready
);

  localparam int unsigned        DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0]  LAST_PTR = '1;

  rf_state_t         state, next_state;
  logic [ADDR_W-1:0] ptr, next_ptr;
  logic              clear_en;
  logic              run_en;
  logic [NUM_WR-1:0] wr_commit;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    state <= next_state;
    ptr   <= next_ptr;
  end

  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    clear_en   = 1'b0;
    run_en     = 1'b0;
    if (reset) begin
      next_state = CLEAR;
      next_ptr   = '0;
    end else begin
      unique case (state)
        CLEAR: begin
          clear_en = 1'b1;
          if (ptr == LAST_PTR) next_state = RUN;
          else                 next_ptr   = ptr + 1'b1;
        end
        RUN:     run_en = 1'b1;
        default: next_state = CLEAR;
      endcase
    end
  end

  assign ready = (state == RUN);

  always_comb begin
    wr_commit = '0;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      wr_commit[w] = reg_write[w] &&
                     !(ZERO_REG && (write_register[w*ADDR_W +: ADDR_W] == '0));
    end
  end

  // NOTE: storage has no reset; the sequencer clears it, keeping it mappable to RAM.
  // Ascending port order makes the highest-index writer's assignment land last.
  always_ff @(posedge clock) begin
    if (clear_en) begin
      mem[ptr] <= '0;
    end else if (run_en) begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wr_commit[w]) mem[write_register[w*ADDR_W +: ADDR_W]] <= write_data[w*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_WR  (NUM_WR),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .addr          (read_register[i*ADDR_W +: ADDR_W]),
      .reg_write     (reg_write),
      .write_register(write_register),
      .write_data    (write_data),
      .mem_row       (mem[read_register[i*ADDR_W +: ADDR_W]]),
      .clearing      (state == CLEAR),
      .read_data     (read_data[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed self-checking bench for register_file_mp (ZERO_REG=1 and =0 instances).
module tb_register_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic [2*AW-1:0] read_register;
  logic [2*DW-1:0] read_data, read_data_nz;
  logic [1:0]      reg_write;
  logic [2*AW-1:0] write_register;
  logic [2*DW-1:0] write_data;
  logic            ready, ready_nz;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1'b1)) dut (
    .clock(clock), .reset(reset), .read_register(read_register), .read_data(read_data),
    .reg_write(reg_write), .write_register(write_register), .write_data(write_data),
    .ready(ready)
  );

  register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1'b0)) dut_nz (
    .clock(clock), .reset(reset), .read_register(read_register), .read_data(read_data_nz),
    .reg_write(reg_write), .write_register(write_register), .write_data(write_data),
    .ready(ready_nz)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    read_register[p*AW +: AW] = a;
  endtask

  task automatic set_wr(input int p, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    reg_write[p]              = en;
    write_register[p*AW +: AW] = a;
    write_data[p*DW +: DW]     = d;
  endtask

  task automatic idle_writes();
    set_wr(0, 1'b0, '0, '0);
    set_wr(1, 1'b0, '0, '0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drops reset after the sampling edge, then walks the 32-edge clear.
  // Stray writes to r3 are held during the clear and must be ignored.
  task automatic run_clear(input string tag);
    #1 reset = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      set_wr(0, 1'b1, 5'd3, 32'hABCD0000);
      step();
      check({tag, "_ready"}, {31'd0, ready}, (i == 32) ? 32'd1 : 32'd0);
      if (i < 32) begin
        #1;
        check({tag, "_rd0_clear"}, read_data[0 +: DW], 32'd0);
        check({tag, "_rd1_clear"}, read_data[DW +: DW], 32'd0);
      end
    end
    idle_writes();
  endtask

  initial begin
    reset = 1'b1;
    read_register = '0;
    idle_writes();
    set_rd(0, 5'd3);
    set_rd(1, 5'd9);

    step();
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_ready_nz", {31'd0, ready_nz}, 32'd0);
    check("rst_rd0", read_data[0 +: DW], 32'd0);
    check("rst_rd1", read_data[DW +: DW], 32'd0);

    run_clear("clr");
    check("clr_ready_nz", {31'd0, ready_nz}, 32'd1);
    #1;
    check("clr_r3_zero", read_data[0 +: DW], 32'd0);

    // Basic write with same-cycle bypass, then storage readback.
    set_wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
    set_rd(1, 5'd5);
    #1 check("wr_bypass_r5", read_data[DW +: DW], 32'hDEADBEEF);
    step();
    idle_writes();
    set_rd(0, 5'd5);
    #1 check("wr_store_r5", read_data[0 +: DW], 32'hDEADBEEF);

    // Two ports on one address: higher index wins both in bypass and storage.
    set_wr(0, 1'b1, 5'd7, 32'h11111111);
    set_wr(1, 1'b1, 5'd7, 32'h22222222);
    set_rd(0, 5'd7);
    #1 check("conf_bypass_r7", read_data[0 +: DW], 32'h22222222);
    step();
    idle_writes();
    set_rd(1, 5'd7);
    #1 check("conf_store_r7", read_data[DW +: DW], 32'h22222222);

    // A disabled higher port must not steal the bypass or the write.
    set_wr(0, 1'b1, 5'd10, 32'hA5A5A5A5);
    set_wr(1, 1'b0, 5'd10, 32'h5A5A5A5A);
    set_rd(0, 5'd10);
    #1 check("dis_bypass_r10", read_data[0 +: DW], 32'hA5A5A5A5);
    step();
    idle_writes();
    #1 check("dis_store_r10", read_data[0 +: DW], 32'hA5A5A5A5);
    set_rd(1, 5'd5);
    #1 check("keep_r5", read_data[DW +: DW], 32'hDEADBEEF);

    // Register 0 handling in both configurations.
    set_wr(0, 1'b1, 5'd0, 32'hFFFFFFFF);
    set_wr(1, 1'b1, 5'd0, 32'hFFFFFFFF);
    set_rd(0, 5'd0);
    set_rd(1, 5'd0);
    #1;
    check("zr_bypass", read_data[0 +: DW], 32'd0);
    check("nz_bypass", read_data_nz[DW +: DW], 32'hFFFFFFFF);
    step();
    idle_writes();
    #1;
    check("zr_store", read_data[DW +: DW], 32'd0);
    check("nz_store", read_data_nz[0 +: DW], 32'hFFFFFFFF);

    // Mid-operation reset wipes r9.
    set_wr(1, 1'b1, 5'd9, 32'h12345678);
    step();
    idle_writes();
    set_rd(0, 5'd9);
    #1 check("mid_r9_before", read_data[0 +: DW], 32'h12345678);
    reset = 1'b1;
    step();
    check("mid_ready_drop", {31'd0, ready}, 32'd0);
    run_clear("mid");
    #1;
    check("mid_r9_after", read_data[0 +: DW], 32'd0);
    check("mid_r9_after_nz", read_data_nz[0 +: DW], 32'd0);
    set_rd(1, 5'd7);
    #1 check("mid_r7_after", read_data[DW +: DW], 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
